// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_issue_ctrl : decodes RV32I ALU fields, issues operands to the ALU and  |
// | returns the captured result over a valid/ready port.                       |
// | Optional feature macro: ALU_ISSUE_ILLEGAL_EN (flags unsupported ops).      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_issue_ctrl #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_imm,
  input  logic [2:0]        req_funct3,
  input  logic              req_funct7b5,
  input  logic [XLEN-1:0]   req_rs1,
  input  logic [XLEN-1:0]   req_rs2,
  input  logic [XLEN-1:0]   req_imm,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [CTRL_W-1:0] alu_control,
  input  logic [XLEN-1:0]   alu_out,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_result,
  output logic              rsp_zero
`ifdef ALU_ISSUE_ILLEGAL_EN
  ,
  output logic              rsp_illegal
`endif
);

  localparam logic [CTRL_W-1:0] C_AND = CTRL_W'(4'b1110);
  localparam logic [CTRL_W-1:0] C_OR  = CTRL_W'(4'b0001);
  localparam logic [CTRL_W-1:0] C_ADD = CTRL_W'(4'b0010);
  localparam logic [CTRL_W-1:0] C_XOR = CTRL_W'(4'b0011);
  localparam logic [CTRL_W-1:0] C_SLL = CTRL_W'(4'b0100);
  localparam logic [CTRL_W-1:0] C_SRL = CTRL_W'(4'b0101);
  localparam logic [CTRL_W-1:0] C_SUB = CTRL_W'(4'b0110);
  localparam logic [CTRL_W-1:0] C_SLT = CTRL_W'(4'b0111);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_accept;
  logic                w_capture;
  logic                w_release;
  logic [CTRL_W-1:0]   w_ctrl;
  logic [XLEN-1:0]     w_b_sel;

  logic [XLEN-1:0]     r_alu_a;
  logic [XLEN-1:0]     r_alu_b;
  logic [CTRL_W-1:0]   r_alu_ctrl;
  logic                r_rsp_valid;
  logic [XLEN-1:0]     r_rsp_result;
  logic                r_rsp_zero;

  // Unsupported encodings (SLTU, SRA/SRAI) fall back to ADD.
  always_comb begin
    w_ctrl = C_ADD;
    case (req_funct3)
      3'b000:  w_ctrl = (!req_is_imm && req_funct7b5) ? C_SUB : C_ADD;
      3'b001:  w_ctrl = C_SLL;
      3'b010:  w_ctrl = C_SLT;
      3'b100:  w_ctrl = C_XOR;
      3'b101:  w_ctrl = req_funct7b5 ? C_ADD : C_SRL;
      3'b110:  w_ctrl = C_OR;
      3'b111:  w_ctrl = C_AND;
      default: w_ctrl = C_ADD;
    endcase
  end

  assign w_b_sel = req_is_imm ? req_imm : req_rs2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_release = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept = 1'b1;
          w_next   = S_EXEC;
        end
      end
      S_EXEC: begin
        w_capture = 1'b1;
        w_next    = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_release = 1'b1;
          w_next    = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_ctrl <= '0;
    end else if (w_accept) begin
      r_alu_a    <= req_rs1;
      r_alu_b    <= w_b_sel;
      r_alu_ctrl <= w_ctrl;
    end
  end

`ifdef ALU_ISSUE_ILLEGAL_EN
  logic w_unsup;
  logic r_op_unsup;
  logic r_rsp_illegal;

  assign w_unsup = (req_funct3 == 3'b011) || ((req_funct3 == 3'b101) && req_funct7b5);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_unsup <= 1'b0;
    end else if (w_accept) begin
      r_op_unsup <= w_unsup;
    end
  end

  // Flagged ops still run through the ALU, but the response is zeroed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_result  <= '0;
      r_rsp_zero    <= 1'b0;
      r_rsp_illegal <= 1'b0;
    end else if (w_capture) begin
      r_rsp_result  <= r_op_unsup ? '0 : alu_out;
      r_rsp_zero    <= r_op_unsup ? 1'b0 : alu_zero;
      r_rsp_illegal <= r_op_unsup;
    end
  end

  assign rsp_illegal = r_rsp_illegal;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
    end else if (w_capture) begin
      r_rsp_result <= alu_out;
      r_rsp_zero   <= alu_zero;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
    end else if (w_capture) begin
      r_rsp_valid <= 1'b1;
    end else if (w_release) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_control = r_alu_ctrl;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_result  = r_rsp_result;
  assign rsp_zero    = r_rsp_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_issue_ctrl : self-checking bench for alu_issue_ctrl with an ALU     |
// | stand-in and a transaction-level reference model. Revision: 1.0            |
// +----------------------------------------------------------------------------+
module tb_alu_issue_ctrl;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid, req_ready, req_is_imm, req_funct7b5;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_rs1, req_rs2, req_imm;
  logic [XLEN-1:0] alu_a, alu_b, alu_out;
  logic [3:0]      alu_control;
  logic            alu_zero;
  logic            rsp_valid, rsp_ready, rsp_zero;
  logic [XLEN-1:0] rsp_result;
`ifdef ALU_ISSUE_ILLEGAL_EN
  logic            rsp_illegal;
`endif

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.XLEN(XLEN), .CTRL_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_is_imm(req_is_imm), .req_funct3(req_funct3), .req_funct7b5(req_funct7b5),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero)
`ifdef ALU_ISSUE_ILLEGAL_EN
    , .rsp_illegal(rsp_illegal)
`endif
  );

  // Stand-in for the combinational ALU on the other side of the interface.
  always_comb begin
    case (alu_control)
      4'b0010: alu_out = alu_a + alu_b;
      4'b0110: alu_out = alu_a - alu_b;
      4'b0100: alu_out = alu_a << alu_b[4:0];
      4'b0101: alu_out = alu_a >> alu_b[4:0];
      4'b0111: alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      4'b0011: alu_out = alu_a ^ alu_b;
      4'b0001: alu_out = alu_a | alu_b;
      4'b1110: alu_out = alu_a & alu_b;
      default: alu_out = 32'd0;
    endcase
    alu_zero = (alu_out == 32'd0);
  end

  function automatic bit is_unsup(input logic [2:0] f3, input logic f7);
    return (f3 == 3'd3) || (f3 == 3'd5 && f7);
  endfunction

  function automatic logic [3:0] exp_ctrl(input logic imm, input logic [2:0] f3, input logic f7);
    logic [3:0] tbl [8];
    tbl = '{4'b0010, 4'b0100, 4'b0111, 4'b0010, 4'b0011, 4'b0101, 4'b0001, 4'b1110};
    if (is_unsup(f3, f7)) return 4'b0010;
    if (f3 == 3'd0 && !imm && f7) return 4'b0110;
    return tbl[f3];
  endfunction

  // Result an RV32I core expects for the instruction.
  function automatic logic [XLEN-1:0] exp_result(input logic imm, input logic [2:0] f3,
                                                  input logic f7, input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
    if (is_unsup(f3, f7)) begin
`ifdef ALU_ISSUE_ILLEGAL_EN
      return 32'd0;
`else
      return a + b;
`endif
    end
    case (f3)
      3'd0:    return (!imm && f7) ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic bit exp_zero(input logic imm, input logic [2:0] f3,
                                  input logic f7, input logic [XLEN-1:0] res);
`ifdef ALU_ISSUE_ILLEGAL_EN
    if (is_unsup(f3, f7)) return 1'b0;
`else
    if (imm && is_unsup(f3, f7)) return (res == 32'd0);
`endif
    return (res == 32'd0);
  endfunction

  // Reference model: m_age = -1 no op in flight, 0 op just accepted, 1 response visible.
  int              m_age;
  logic [XLEN-1:0] m_a, m_b, m_res, m_pres;
  logic [3:0]      m_ctrl;
  logic            m_zero, m_pzero, m_ill, m_pill;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_age <= -1; m_a <= '0; m_b <= '0; m_ctrl <= '0;
      m_res <= '0; m_zero <= 1'b0; m_ill <= 1'b0;
      m_pres <= '0; m_pzero <= 1'b0; m_pill <= 1'b0;
    end else if (m_age == 0) begin
      m_res <= m_pres; m_zero <= m_pzero; m_ill <= m_pill; m_age <= 1;
    end else if (m_age >= 1 && rsp_ready) begin
      m_age <= -1;
    end else if (m_age < 0 && req_valid) begin
      m_a    <= req_rs1;
      m_b    <= req_is_imm ? req_imm : req_rs2;
      m_ctrl <= exp_ctrl(req_is_imm, req_funct3, req_funct7b5);
      m_pres <= exp_result(req_is_imm, req_funct3, req_funct7b5, req_rs1,
                           req_is_imm ? req_imm : req_rs2);
      m_pzero <= exp_zero(req_is_imm, req_funct3, req_funct7b5,
                          exp_result(req_is_imm, req_funct3, req_funct7b5, req_rs1,
                                     req_is_imm ? req_imm : req_rs2));
`ifdef ALU_ISSUE_ILLEGAL_EN
      m_pill <= is_unsup(req_funct3, req_funct7b5);
`else
      m_pill <= 1'b0;
`endif
      m_age <= 0;
    end
  end

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_req_ready", 32'(req_ready), 32'(m_age < 0));
      chk("m_rsp_valid", 32'(rsp_valid), 32'(m_age >= 1));
      chk("m_alu_a", alu_a, m_a);
      chk("m_alu_b", alu_b, m_b);
      chk("m_alu_control", 32'(alu_control), 32'(m_ctrl));
      chk("m_rsp_result", rsp_result, m_res);
      chk("m_rsp_zero", 32'(rsp_zero), 32'(m_zero));
`ifdef ALU_ISSUE_ILLEGAL_EN
      chk("m_rsp_illegal", 32'(rsp_illegal), 32'(m_ill));
`endif
    end
  end

  task automatic drive_req(input logic imm, input logic [2:0] f3, input logic f7,
                           input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    req_valid = 1'b1; req_is_imm = imm; req_funct3 = f3; req_funct7b5 = f7;
    req_rs1 = a; req_rs2 = imm ? 32'hdead_beef : b; req_imm = imm ? b : 32'h1234_5678;
  endtask

  // One request with literal expectations; starts and ends at a negedge.
  task automatic run_op(input string name, input logic imm, input logic [2:0] f3,
                        input logic f7, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [3:0] ectrl, input logic [XLEN-1:0] eres,
                        input logic ezero, input logic eill);
    int n = 0;
    @(negedge clk);
    drive_req(imm, f3, f7, a, b);
    rsp_ready = 1'b0;
    while (!req_ready && n < 10) begin @(negedge clk); n++; end
    if (!req_ready) begin
      tests++; fails++;
      $display("FAIL %s_accept: req_ready stuck low, expected 1", name);
    end
    @(negedge clk);
    req_valid = 1'b0;
    chk({name, "_exec_valid"}, 32'(rsp_valid), 32'd0);
    chk({name, "_ctrl"}, 32'(alu_control), 32'(ectrl));
    @(negedge clk);
    chk({name, "_resp_valid"}, 32'(rsp_valid), 32'd1);
    chk({name, "_result"}, rsp_result, eres);
    chk({name, "_zero"}, 32'(rsp_zero), 32'(ezero));
`ifdef ALU_ISSUE_ILLEGAL_EN
    chk({name, "_illegal"}, 32'(rsp_illegal), 32'(eill));
`else
    if (eill) chk({name, "_illegal_ignored"}, 32'(rsp_valid), 32'd1);
`endif
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({name, "_done"}, 32'(rsp_valid), 32'd0);
  endtask

  function automatic logic [XLEN-1:0] rnd_word();
    logic [XLEN-1:0] w;
    w = $urandom;
    case ($urandom_range(0, 3))
      0:       return w & 32'h1f;
      1:       return {{20{w[11]}}, w[11:0]};
      default: return w;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_is_imm = 1'b0; req_funct3 = 3'd0;
    req_funct7b5 = 1'b0; req_rs1 = '0; req_rs2 = '0; req_imm = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_alu_control", 32'(alu_control), 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    run_op("add",  1'b0, 3'd0, 1'b0, 32'd5, 32'd3, 4'b0010, 32'h8, 1'b0, 1'b0);
    run_op("sub",  1'b0, 3'd0, 1'b1, 32'd5, 32'd5, 4'b0110, 32'h0, 1'b1, 1'b0);
    run_op("addi", 1'b1, 3'd0, 1'b1, 32'd5, 32'd3, 4'b0010, 32'h8, 1'b0, 1'b0);
    run_op("slt",  1'b0, 3'd2, 1'b0, 32'hffff_fffe, 32'd1, 4'b0111, 32'h1, 1'b0, 1'b0);
    run_op("srl",  1'b0, 3'd5, 1'b0, 32'h8000_0000, 32'd4, 4'b0101, 32'h0800_0000, 1'b0, 1'b0);
    run_op("andi", 1'b1, 3'd7, 1'b0, 32'hf0f0_f0f0, 32'h0000_0ff0, 4'b1110, 32'h0000_00f0, 1'b0, 1'b0);
`ifdef ALU_ISSUE_ILLEGAL_EN
    run_op("sltu", 1'b0, 3'd3, 1'b0, 32'd2, 32'd1, 4'b0010, 32'h0, 1'b0, 1'b1);
    run_op("sra",  1'b0, 3'd5, 1'b1, 32'd8, 32'd1, 4'b0010, 32'h0, 1'b0, 1'b1);
`else
    run_op("sltu", 1'b0, 3'd3, 1'b0, 32'd2, 32'd1, 4'b0010, 32'h3, 1'b0, 1'b1);
    run_op("sra",  1'b0, 3'd5, 1'b1, 32'd8, 32'd1, 4'b0010, 32'h9, 1'b0, 1'b1);
`endif

    // Back-pressure: response held while a new request waits.
    @(negedge clk);
    drive_req(1'b0, 3'd0, 1'b0, 32'd10, 32'd20);
    @(negedge clk);
    drive_req(1'b0, 3'd0, 1'b0, 32'd99, 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_result", rsp_result, 32'd30);
      chk("hold_alu_a", alu_a, 32'd10);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("hold_release_valid", 32'(rsp_valid), 32'd0);
    chk("hold_release_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("hold_next_alu_a", alu_a, 32'd99);
    @(negedge clk);
    chk("hold_next_result", rsp_result, 32'd100);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset while the op sits in EXEC.
    drive_req(1'b0, 3'd0, 1'b0, 32'd7, 32'd9);
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_exec_alu_a", alu_a, 32'd0);
    chk("rst_exec_alu_control", 32'(alu_control), 32'd0);
    chk("rst_exec_rsp_result", rsp_result, 32'd0);
    chk("rst_exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_exec_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst_add", 1'b0, 3'd0, 1'b0, 32'd1, 32'd1, 4'b0010, 32'h2, 1'b0, 1'b0);

    // Random traffic; the model and compare process do the checking.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      req_valid    = 1'($urandom_range(0, 1));
      req_is_imm   = 1'($urandom_range(0, 1));
      req_funct3   = 3'($urandom_range(0, 7));
      req_funct7b5 = 1'($urandom_range(0, 1));
      req_rs1      = rnd_word();
      req_rs2      = ($urandom_range(0, 5) == 0) ? req_rs1 : rnd_word();
      req_imm      = {{20{req_rs2[11]}}, req_rs2[11:0]} ^ 32'(req_funct3);
      rsp_ready    = ($urandom_range(0, 2) != 0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
